alu_multiword_seq: RTL
======================

// Module: alu_multiword_seq
// PURPOSE
//  Multi-cycle operand sequencer directly upstream of ALU_16b (instantiated inside).
//  Splits WORDS*16-bit operands into 16-bit words, feeds ALU_16b LSW first, chains the carry through ADC/SBB.
//  Accumulates the wide result and final C/Z/N/V flags; start/busy/done handshake to the control unit.
// PARAMETERS
//  WORDS  2  number of 16-bit words per operand (legal 1..4); operand width W = 16*WORDS
// PORTS
//  clk     in   1    system clock, all state updates on rising edge
//  rst     in   1    synchronous, active-high reset
//  start   in   1    request; sampled only when busy=0
//  op      in   2    00 ADD, 01 ADC, 10 SUB, 11 SBB (same encoding as ALU_16b sel)
//  cin     in   1    external carry/borrow-in, used by ADC/SBB on word 0 only
//  opA     in   W    operand A, captured on accepted start
//  opB     in   W    operand B, captured on accepted start
//  busy    out  1    high while words are being processed
//  done    out  1    one-cycle pulse: result/flags valid
//  result  out  W    wide result, held until next accepted start
//  C       out  1    carry-out (ADD/ADC) or borrow-out (SUB/SBB) of MSW
//  Z       out  1    1 iff all W result bits are 0
//  N       out  1    result[W-1]
//  V       out  1    signed overflow, V of MSW
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, C=Z=N=V=0, word index=0, carry latch=0.
//  Reset mid-operation aborts: next cycle identical to post-reset; no done pulse issued.
//  FSM: IDLE -> RUN on start; RUN -> DONE after word WORDS-1; DONE -> RUN if start else IDLE.
//  Accept: start=1 with state IDLE or DONE (busy=0) captures opA/opB/op/cin at edge T.
//  start while busy=1 is ignored: no queuing, no effect on the current operation.
//  RUN, index k=0..WORDS-1, one word per cycle; ALU inputs come from registered operand words only.
//   k=0: alu sel=op, alu Cin = op[0] ? cin : 0.
//   k>0: alu sel={op[1],1} (ADC or SBB), alu Cin = carry latch (ALU C of word k-1).
//   Edge T+1+k: result[16k+:16] <= alu Sum; carry latch <= alu C; Z accumulator &= alu Z.
//  ALU_16b convention: SBB = A-B-Cin; C after SUB/SBB is borrow (1 = borrow).
//  Flags: C, N, V from word WORDS-1; Z = AND of all word Z. All registered at edge T+WORDS.
//  done=1 in the cycle after edge T+WORDS, exactly one cycle; busy=1 from T+1 through T+WORDS.
//  Latency: start edge to done = WORDS clocks; back-to-back throughput one op per WORDS+1 clocks.
//  Outside RUN, ALU inputs are driven to sel=00, A=B=0, Cin=0.
//  result and flags unchanged between done and next accepted start (and cleared only by rst).
//  WORDS=1 degenerates to a registered single-cycle ALU_16b wrapper, done at T+1.
// STRUCTURE
//  Shared package: op encodings (OP_ADD/ADC/SUB/SBB), FSM state constants (IDLE/RUN/DONE).
//  Sub-module: ALU_16b, instance u_alu, the only combinational datapath.
//  Word index counter, carry latch, Z accumulator and operand shift registers stay inline in this module.
// TESTING (WORDS=2 unless noted)
//  ADD 0000FFFF+00000001, cin=0 -> result 00010000, C0 Z0 N0 V0; done 2 clocks after start edge.
//  SUB 00010000-00000001 -> 0000FFFF, C0 Z0 N0 V0 (borrow from word 0 consumed by SBB in word 1).
//  SUB 12345678-12345678 -> 00000000, C0 Z1 N0 V0; ADD FFFFFFFF+00000001 -> 00000000, C1 Z1.
//  ADD 7FFFFFFF+00000001 -> 80000000, C0 Z0 N1 V1; ADC 00000001+00000002, cin=1 -> 00000004.
//  start pulsed again while busy -> ignored, result/done timing of first op unchanged; start in DONE cycle accepted.
//  rst asserted in cycle after first word captured -> next cycle busy0 done0 result0 flags0; no done pulse.

Source files
------------

// File: rtl/alu_multiword_seq_pkg.sv
// Shared encodings for the multi-word ALU sequencer.
// Op codes match the ALU_16b sel field.
package alu_multiword_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_multiword_seq_alu.sv
// 16-bit add/subtract ALU with carry chaining.
// After SUB/SBB, C is a borrow (1 = borrow).
module ALU_16b
    import alu_multiword_seq_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        C,
    output logic        Z,
    output logic        N,
    output logic        V
);

    logic [16:0] ext;
    logic        ci;
    logic        sub;

    always_comb begin
        ci  = 1'b0;
        sub = 1'b0;
        unique case (sel)
            OP_ADD: begin ci = 1'b0; sub = 1'b0; end
            OP_ADC: begin ci = Cin;  sub = 1'b0; end
            OP_SUB: begin ci = 1'b0; sub = 1'b1; end
            OP_SBB: begin ci = Cin;  sub = 1'b1; end
            default: begin ci = 1'b0; sub = 1'b0; end
        endcase
        if (sub) begin
            ext = {1'b0, A} - {1'b0, B} - {16'd0, ci};
        end else begin
            ext = {1'b0, A} + {1'b0, B} + {16'd0, ci};
        end
        Sum = ext[15:0];
        C   = ext[16];
        Z   = (ext[15:0] == 16'd0);
        N   = ext[15];
        // Overflow: result sign differs from A when operand signs make it impossible
        if (sub) begin
            V = (A[15] != B[15]) && (ext[15] != A[15]);
        end else begin
            V = (A[15] == B[15]) && (ext[15] != A[15]);
        end
    end

endmodule

// File: rtl/alu_multiword_seq.sv
// Sequences WORDS*16-bit add/sub through ALU_16b one word per cycle,
// LSW first, chaining carry/borrow and accumulating the wide result and flags.
module alu_multiword_seq
    import alu_multiword_seq_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic                  cin,
    input  logic [16*WORDS-1:0]   opA,
    input  logic [16*WORDS-1:0]   opB,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   result,
    output logic                  C,
    output logic                  Z,
    output logic                  N,
    output logic                  V
);

    localparam int W = 16 * WORDS;
    localparam logic [1:0] LAST = 2'(WORDS - 1);

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           zacc_q, zacc_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic           cin_q, cin_d;
    logic [W-1:0]   result_q, result_d;
    logic           c_q, c_d;
    logic           z_q, z_d;
    logic           n_q, n_d;
    logic           v_q, v_d;

    logic [1:0]     alu_sel;
    logic [15:0]    alu_a, alu_b, alu_sum;
    logic           alu_cin, alu_c, alu_z, alu_n, alu_v;

    ALU_16b u_alu (
        .sel (alu_sel),
        .A   (alu_a),
        .B   (alu_b),
        .Cin (alu_cin),
        .Sum (alu_sum),
        .C   (alu_c),
        .Z   (alu_z),
        .N   (alu_n),
        .V   (alu_v)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cin_d    = cin_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        alu_sel  = OP_ADD;
        alu_a    = 16'd0;
        alu_b    = 16'd0;
        alu_cin  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = opA;
                    b_d     = opB;
                    op_d    = op;
                    cin_d   = cin;
                    idx_d   = 2'd0;
                    carry_d = 1'b0;
                    zacc_d  = 1'b1;
                end
            end
            RUN: begin
                // Upper words always chain through ADC/SBB
                if (idx_q == 2'd0) begin
                    alu_sel = op_q;
                    alu_cin = op_q[0] & cin_q;
                end else begin
                    alu_sel = {op_q[1], 1'b1};
                    alu_cin = carry_q;
                end
                alu_a = a_q[15:0];
                alu_b = b_q[15:0];
                for (int k = 0; k < WORDS; k++) begin
                    if (idx_q == 2'(k)) begin
                        result_d[16*k +: 16] = alu_sum;
                    end
                end
                carry_d = alu_c;
                zacc_d  = zacc_q & alu_z;
                a_d     = a_q >> 16;
                b_d     = b_q >> 16;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = 2'd0;
                    c_d     = alu_c;
                    z_d     = zacc_q & alu_z;
                    n_d     = alu_n;
                    v_d     = alu_v;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'd0;
            cin_q    <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign C      = c_q;
    assign Z      = z_q;
    assign N      = n_q;
    assign V      = v_q;

endmodule
